// File: rtl/fifo_pkg.sv
// Shared FIFO defaults plus the write-port arbiter's state encoding.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotate-priority encoder: first set req bit strictly after rr, wrapping, with rr itself last.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int pos;

    // Walk from lowest to highest priority so the nearest candidate after rr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = (int'(rr) + k) % NUM_REQ;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the async FIFO write port (winc/wdata registered).
// Define FIFO_WR_ARB_BURST_EN for multi-word ownership; otherwise grants rotate every word.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_pkg::NUM_REQ,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = fifo_pkg::MAX_BURST
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          wfull,
    input  logic                          wafull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    import fifo_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int EFF_BURST = MAX_BURST;
`else
    localparam int EFF_BURST = 1;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_BURST);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(NUM_REQ - 1);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] rr, rr_nx;
    logic [IDX_W-1:0] owner_nx;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             take;
    logic             ok;

    // The registered write still in flight consumes the last free slot when wafull is set.
    assign ok = !wfull && !(wafull && winc);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .rr    (rr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rr_nx    = rr;
        owner_nx = owner;
        sel      = owner;
        take     = 1'b0;
        gnt      = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_found && ok) begin
                    take     = 1'b1;
                    sel      = pick_idx;
                    owner_nx = pick_idx;
                    cnt_nx   = CNT_W'(1);
                    if (EFF_BURST == 1) begin
                        rr_nx = pick_idx;
                    end else begin
                        state_nx = ARB_BURST;
                    end
                end
            end
            ARB_BURST: begin
                if (!req[owner]) begin
                    state_nx = ARB_IDLE;
                    rr_nx    = owner;
                end else if (ok) begin
                    take   = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (cnt_nx == CNT_LAST) begin
                        state_nx = ARB_IDLE;
                        rr_nx    = owner;
                    end
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
        // A word granted while reset is sampled is dropped, so never advertise it.
        if (wrst) begin
            take = 1'b0;
        end
        if (take) begin
            gnt[sel] = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state <= ARB_IDLE;
            cnt   <= '0;
            rr    <= RR_INIT;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rr    <= rr_nx;
            owner <= owner_nx;
            busy  <= (state_nx == ARB_BURST);
        end
    end

    // FIFO write port stage: one cycle after the grant.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            winc  <= 1'b0;
            wdata <= '0;
        end else begin
            winc <= take;
            if (take) begin
                wdata <= req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
